// File: rtl/instruction_decode_stage.sv
// ID stage: decodes fetch output, reads the 8x16 register file and registers it into ID/EX (1-cycle latency).
// Requests a fetch stall on load-use hazards; ID_WB_BYPASS_EN forwards same-cycle writeback into operands.
module instruction_decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  if_pc,
  input  logic [15:0] if_instruction,
  input  logic        wb_we,
  input  logic [2:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        id_valid,
  output logic [2:0]  id_pc,
  output logic [3:0]  id_opcode,
  output logic [2:0]  id_rd,
  output logic [15:0] id_rs1_data,
  output logic [15:0] id_rs2_data,
  output logic [15:0] id_imm,
  output logic [2:0]  id_alu_op,
  output logic        id_reg_write,
  output logic        id_mem_read,
  output logic        id_mem_write,
  output logic        id_branch,
  output logic        halted,
  output logic        illegal
);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_ADDI  = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_BEQ   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef enum logic [1:0] {S_FLUSH, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        issue;
  logic [15:0] rf [8];

  logic [3:0]  op;
  logic [2:0]  f_rd, f_rs1, f_src2;
  logic        reads_rs1, reads_src2, op_illegal;
  logic [15:0] rs1_val, src2_val;
  logic [2:0]  alu_op_d;
  logic        reg_write_d, mem_read_d, mem_write_d, branch_d;

  assign op         = if_instruction[15:12];
  assign f_rd       = if_instruction[11:9];
  assign f_rs1      = if_instruction[8:6];
  // STORE and BEQ carry their second source in the rd slot
  assign f_src2     = (op == OP_STORE || op == OP_BEQ) ? f_rd : if_instruction[5:3];
  assign reads_rs1  = (op >= OP_ADD) && (op <= OP_STORE);
  assign reads_src2 = ((op >= OP_ADD) && (op <= OP_OR)) || op == OP_STORE || op == OP_BEQ;
  assign op_illegal = (op >= 4'd9) && (op <= 4'd14);

  always_comb begin
    rs1_val  = rf[f_rs1];
    src2_val = rf[f_src2];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_rd != 3'd0 && wb_rd == f_rs1)  rs1_val  = wb_data;
    if (wb_we && wb_rd != 3'd0 && wb_rd == f_src2) src2_val = wb_data;
`endif
    if (f_rs1 == 3'd0)  rs1_val  = '0;
    if (f_src2 == 3'd0) src2_val = '0;
  end

  assign stall = (state_q == S_RUN) && id_valid && id_mem_read && (id_rd != 3'd0) &&
                 ((reads_rs1 && id_rd == f_rs1) || (reads_src2 && id_rd == f_src2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FLUSH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      S_FLUSH: state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          issue = 1'b1;
          if (op == OP_HALT) state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FLUSH;
    endcase
  end

  always_comb begin
    alu_op_d    = ALU_ADD;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    case (op)
      OP_ADD:   reg_write_d = 1'b1;
      OP_SUB:   begin alu_op_d = ALU_SUB; reg_write_d = 1'b1; end
      OP_AND:   begin alu_op_d = ALU_AND; reg_write_d = 1'b1; end
      OP_OR:    begin alu_op_d = ALU_OR;  reg_write_d = 1'b1; end
      OP_ADDI:  reg_write_d = 1'b1;
      OP_LOAD:  begin reg_write_d = 1'b1; mem_read_d = 1'b1; end
      OP_STORE: mem_write_d = 1'b1;
      OP_BEQ:   begin alu_op_d = ALU_SUB; branch_d = 1'b1; end
      default:  ;
    endcase
    if (f_rd == 3'd0) reg_write_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_rd        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_alu_op    <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
    end else if (issue) begin
      id_valid     <= 1'b1;
      id_pc        <= if_pc;
      id_opcode    <= op_illegal ? 4'd0 : op;
      id_rd        <= f_rd;
      id_rs1_data  <= rs1_val;
      id_rs2_data  <= src2_val;
      id_imm       <= {{10{if_instruction[5]}}, if_instruction[5:0]};
      id_alu_op    <= alu_op_d;
      id_reg_write <= reg_write_d;
      id_mem_read  <= mem_read_d;
      id_mem_write <= mem_write_d;
      id_branch    <= branch_d;
    end else begin
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_rd        <= '0;
      id_rs1_data  <= '0;
      id_rs2_data  <= '0;
      id_imm       <= '0;
      id_alu_op    <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_branch    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      halted  <= (state_d == S_HALT);
      illegal <= illegal | (issue & op_illegal);
    end
  end

  // Writeback is accepted in every state, including stall and HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != 3'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end

endmodule
